round_countdown: RTL and testbench
==================================

# round_countdown

Loadable two-digit BCD round timer for the whack-a-mole game. It divides the board clock to a 1 Hz tick and counts a round length down from START_SEC to 00, then saturates and flags expiry. It is the down-counting counterpart of the game's up-counting phase counter, and its digits drive the seven-segment display path directly.

## Interface

- CLK_HZ, 26_000_000, clock cycles per second tick; minimum 2
- START_SEC, 60, round length in seconds; legal range 1..99
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk
- start  in  1  single-cycle request to begin or restart a round
- pause  in  1  level; while high in RUN, the countdown freezes
- tens  out  4  BCD tens digit of remaining seconds
- ones  out  4  BCD ones digit of remaining seconds
- running  out  1  high while state is RUN
- done  out  1  high while state is DONE
- expired  out  1  one-cycle pulse on entry to DONE
- warn  out  1  low-time indicator (see Configuration)

## Operation

- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Reset (sampled at an edge):
  - state=IDLE, {tens,ones}=BCD(START_SEC), prescaler=0.
  - running=0, done=0, expired=0, warn=0.
  - Reset overrides every other input in the same cycle.
- IDLE:
  - start=1 with pause=0 goes to RUN, prescaler=0.
  - start=1 with pause=1 goes to PAUSE, prescaler=0.
  - Digits hold START_SEC.
- RUN:
  - Prescaler counts 0..CLK_HZ-1.
  - At CLK_HZ-1 it wraps to 0 and the BCD value decrements by 1.
  - If the decremented value is 00, state goes to DONE and expired=1 for that cycle.
  - pause=1 goes to PAUSE. Prescaler and digits hold, and the terminal-count decrement is suppressed in that same cycle.
  - start is ignored.
- PAUSE:
  - Prescaler and digits frozen.
  - pause=0 returns to RUN, continuing from the held prescaler value. No time is lost or gained.
  - start is ignored.
- DONE:
  - Digits saturate at 00 with no wrap to 99.
  - start=1 reloads START_SEC, clears the prescaler and goes to RUN, or to PAUSE if pause=1.
- BCD decrement:
  - If ones≠0: ones−1.
  - Otherwise: ones=9, tens−1.
  - Digits never leave 0..9.
- The prescaler is wide enough to hold CLK_HZ-1 (25 bits at the default).

## Timing

- A start sampled at edge N puts state=RUN and running=1 from edge N+1.
- The first decrement occurs at edge N+CLK_HZ.
- Expiry occurs at edge N+START_SEC·CLK_HZ, when paused cycles are zero:
  - digits read 00, done=1, running=0, expired=1 for exactly one cycle.
- Each cycle spent in PAUSE delays expiry by exactly one cycle.
- Entering or leaving PAUSE takes effect one edge after pause changes.
- A restart from DONE is identical in timing to a start from IDLE.

## Configuration

- COUNTDOWN_WARN_EN defined:
  - warn=1 while state is RUN or PAUSE and the remaining value is ≤ 10 s (tens=1,ones=0 or tens=0).
  - warn=0 in IDLE and DONE.
- COUNTDOWN_WARN_EN undefined:
  - warn is tied to 0 and no comparator logic is present.
  - All other behaviour is unchanged.

## Test plan

- CLK_HZ=4, START_SEC=3; reset, then start at cycle 0:
  - running=1 at cycle 1.
  - Digits 02 at cycle 4, 01 at cycle 8, 00 at cycle 12.
  - At cycle 12: expired pulses for one cycle, done=1, and digits stay 00 for 20 more cycles.
- CLK_HZ=4, START_SEC=3; start, then pause high for cycles 2..7:
  - Digits stay 03 through the pause.
  - 02 appears at cycle 10; expiry at cycle 18.
- START_SEC=20, CLK_HZ=2; run:
  - Digits pass 20→19 (ones wraps to 9, tens decrements) and later 10→09.
  - No non-BCD digit ever appears.
- In DONE, pulse start:
  - Digits reload to START_SEC and running=1 on the next edge.
  - expired stays low until the next expiry.
- Assert reset mid-RUN with digits at 01 and prescaler nonzero:
  - Next edge gives IDLE, digits=START_SEC, all flags 0.
  - start pulses during RUN and PAUSE have no effect.
- With COUNTDOWN_WARN_EN, START_SEC=12:
  - warn rises when digits reach 10 and stays high through 00 pre-DONE.
  - warn falls on entry to DONE.
  - Without the macro, warn stays 0 throughout.

Source files
------------

// File: rtl/round_countdown.sv
// round_countdown: loadable two-digit BCD round timer for the whack-a-mole game.
//   Divides clk to a 1 Hz tick and counts START_SEC down to 00, then saturates.
//   Optional low-time indicator is built only when COUNTDOWN_WARN_EN is defined.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   start    in   single-cycle begin/restart request (honoured in IDLE and DONE)
//   pause    in   level; freezes the countdown while high
//   tens     out  BCD tens digit of remaining seconds
//   ones     out  BCD ones digit of remaining seconds
//   running  out  high while in RUN
//   done     out  high while in DONE
//   expired  out  one-cycle pulse on entry to DONE
//   warn     out  remaining time <= 10 s while counting (0 without COUNTDOWN_WARN_EN)
module round_countdown #(
   parameter int CLK_HZ    = 26_000_000,
   parameter int START_SEC = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       running,
   output logic       done,
   output logic       expired,
   output logic       warn
);
   localparam int PW = $clog2(CLK_HZ);
   localparam logic [3:0] T0 = 4'(START_SEC / 10);
   localparam logic [3:0] O0 = 4'(START_SEC % 10);
   localparam logic [PW-1:0] P_MAX = PW'(CLK_HZ - 1);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
   state_t r_state, w_state;
   logic [PW-1:0] r_pre, w_pre;
   logic [3:0] r_tens, r_ones, w_tens, w_ones;
   logic r_running, r_done, r_expired, r_warn;
   logic w_step, w_warn;
   always_comb begin
      w_state = r_state;
      w_pre   = r_pre;
      w_tens  = r_tens;
      w_ones  = r_ones;
      w_step  = 1'b0;
      case (r_state)
         IDLE: if (start) begin
            w_state = pause ? PAUSE : RUN;
            w_pre   = '0;
         end
         RUN: if (pause) w_state = PAUSE;
              else w_step = 1'b1;
         // Leaving PAUSE counts on the same edge, so each paused edge costs exactly one cycle.
         PAUSE: if (!pause) begin
            w_state = RUN;
            w_step  = 1'b1;
         end
         DONE: if (start) begin
            w_state = pause ? PAUSE : RUN;
            w_pre   = '0;
            w_tens  = T0;
            w_ones  = O0;
         end
         default: w_state = IDLE;
      endcase
      if (w_step) begin
         w_pre = (r_pre == P_MAX) ? '0 : r_pre + PW'(1);
         if (r_pre == P_MAX) begin
            w_ones = (r_ones != 4'd0) ? r_ones - 4'd1 : 4'd9;
            w_tens = (r_ones != 4'd0) ? r_tens : r_tens - 4'd1;
            w_state = (w_tens == 4'd0 && w_ones == 4'd0) ? DONE : RUN;
         end
      end
   end
`ifdef COUNTDOWN_WARN_EN
   assign w_warn = (w_state == RUN || w_state == PAUSE) &&
                   (w_tens == 4'd0 || (w_tens == 4'd1 && w_ones == 4'd0));
`else
   assign w_warn = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_pre     <= '0;
         r_tens    <= T0;
         r_ones    <= O0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_expired <= 1'b0;
         r_warn    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_pre     <= w_pre;
         r_tens    <= w_tens;
         r_ones    <= w_ones;
         r_running <= (w_state == RUN);
         r_done    <= (w_state == DONE);
         r_expired <= (w_state == DONE) && (r_state != DONE);
         r_warn    <= w_warn;
      end
   end
   assign tens    = r_tens;
   assign ones    = r_ones;
   assign running = r_running;
   assign done    = r_done;
   assign expired = r_expired;
   assign warn    = r_warn;
endmodule

// File: tb/tb_round_countdown.sv
// tb_round_countdown: scoreboard bench for round_countdown (two configurations side by side).
module tb_round_countdown;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start1 = 1'b0, pause1 = 1'b0, start2 = 1'b0, pause2 = 1'b0;
   logic [3:0] tens1, ones1, tens2, ones2;
   logic running1, done1, expired1, warn1, running2, done2, expired2, warn2;
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   typedef struct {
      int st;
      int left;
      bit ex;
   } m_t;
   m_t m1, m2;
   logic [23:0] q[$];
   logic [23:0] e;
   logic [11:0] o1, o2;

   round_countdown #(.CLK_HZ(4), .START_SEC(3)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .pause(pause1),
      .tens(tens1), .ones(ones1), .running(running1), .done(done1),
      .expired(expired1), .warn(warn1));

   round_countdown #(.CLK_HZ(2), .START_SEC(20)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .pause(pause2),
      .tens(tens2), .ones(ones2), .running(running2), .done(done2),
      .expired(expired2), .warn(warn2));

   always #5 clk = ~clk;

   // Model tracks cycles left until expiry; displayed seconds are that value rounded up.
   function automatic m_t nx(m_t m, logic r, logic s, logic p, int hz, int sec);
      m_t n = m;
      n.ex = 1'b0;
      if (r) begin
         n.st = 0;
         n.left = sec * hz;
      end else if (m.st == 0 || m.st == 3) begin
         if (s) begin
            n.left = sec * hz;
            n.st = p ? 2 : 1;
         end
      end else if (p) begin
         n.st = 2;
      end else begin
         n.left = m.left - 1;
         n.st = (n.left == 0) ? 3 : 1;
         n.ex = (n.left == 0);
      end
      return n;
   endfunction

   function automatic logic [11:0] expv(m_t m, int hz);
      int sec = (m.left + hz - 1) / hz;
      logic w;
`ifdef COUNTDOWN_WARN_EN
      w = (m.st == 1 || m.st == 2) && sec <= 10;
`else
      w = 1'b0;
`endif
      return {4'(sec / 10), 4'(sec % 10), m.st == 1, m.st == 3, m.ex, w};
   endfunction

   task automatic step(input logic r, input logic s1, input logic p1, input logic s2, input logic p2);
      reset = r;
      start1 = s1;
      pause1 = p1;
      start2 = s2;
      pause2 = p2;
      m1 = nx(m1, r, s1, p1, 4, 3);
      m2 = nx(m2, r, s2, p2, 2, 20);
      q.push_back({expv(m1, 4), expv(m2, 2)});
      @(posedge clk);
      #1;
      e = q.pop_front();
      o1 = {tens1, ones1, running1, done1, expired1, warn1};
      o2 = {tens2, ones2, running2, done2, expired2, warn2};
      checks++;
      assert (o1 === e[23:12]) else begin
         errors++;
         $error("FAIL dut1 cyc=%0d {tens,ones,run,done,exp,warn} observed=%h expected=%h", cyc, o1, e[23:12]);
      end
      checks++;
      assert (o2 === e[11:0]) else begin
         errors++;
         $error("FAIL dut2 cyc=%0d {tens,ones,run,done,exp,warn} observed=%h expected=%h", cyc, o2, e[11:0]);
      end
      cyc++;
   endtask

   initial begin
      m1 = '{0, 12, 1'b0};
      m2 = '{0, 40, 1'b0};
      repeat (2) step(1, 0, 0, 0, 0);
      // both start together; dut1 expires at 12, dut2 at 40 passing 20->19 and 10->09
      step(0, 1, 0, 1, 0);
      repeat (44) step(0, 0, 0, 0, 0);
      // restart dut1 from DONE, pause edges 2..7, ignored start pulses in PAUSE and RUN
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      for (int i = 2; i <= 7; i++) step(0, i == 5, 1, 0, 0);
      for (int i = 8; i <= 25; i++) step(0, i == 9, 0, 0, 0);
      // restart from DONE straight into PAUSE
      step(0, 1, 1, 0, 0);
      repeat (3) step(0, 0, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      // reset mid-RUN with digits at 01 and prescaler nonzero
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      for (int i = 1; i <= 9; i++) step(0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      // mixed random traffic on both instances
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 79) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
